// File: rtl/instruction_loader.sv
// Writer side of the DDS instruction memory: parses a framed byte stream,
// writes 11-bit words sequentially from address 0 and validates count/checksum.
module instruction_loader #(
  parameter int unsigned DATA_WIDTH     = 11,
  parameter int unsigned ADDR_WIDTH     = 17,
  parameter int unsigned MAX_WORDS      = 66583,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH-1:0] words_written,
  output logic                  start_run
);

  localparam int unsigned CW = 24;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]  SYNC = 8'hA5;

  typedef enum logic [3:0] {
    IDLE, CNT2, CNT1, CNT0, DHI, DLO, CSUM, DONE, ERROR
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         count_q, count_n;
  logic [7:0]            hi_q, hi_n;
  logic [7:0]            csum_q, csum_n;
  logic [TW-1:0]         tcnt_q, tcnt_n;
  logic                  ready_n, we_n, busy_n, done_n, err_n, start_n;
  logic [ADDR_WIDTH-1:0] addr_n, ww_n;
  logic [DATA_WIDTH-1:0] din_n;
  logic [1:0]            code_n;
  logic                  accept;
  logic [CW-1:0]         full_count;

  assign accept     = s_valid && s_ready;
  assign full_count = {count_q[15:0], s_data};

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count_q       <= '0;
      hi_q          <= '0;
      csum_q        <= '0;
      tcnt_q        <= '0;
      s_ready       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_din       <= '0;
      busy          <= 1'b0;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
      err_code      <= 2'b00;
      words_written <= '0;
      start_run     <= 1'b0;
    end else begin
      state         <= state_n;
      count_q       <= count_n;
      hi_q          <= hi_n;
      csum_q        <= csum_n;
      tcnt_q        <= tcnt_n;
      s_ready       <= ready_n;
      mem_we        <= we_n;
      mem_addr      <= addr_n;
      mem_din       <= din_n;
      busy          <= busy_n;
      load_done     <= done_n;
      load_error    <= err_n;
      err_code      <= code_n;
      words_written <= ww_n;
      start_run     <= start_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n = state;
    count_n = count_q;
    hi_n    = hi_q;
    csum_n  = csum_q;
    tcnt_n  = tcnt_q;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    din_n   = mem_din;
    ww_n    = words_written;
    done_n  = load_done;
    err_n   = load_error;
    code_n  = err_code;
    start_n = 1'b0;
    ready_n = 1'b1;
    busy_n  = 1'b0;

    case (state)
      IDLE: begin
        if (accept && s_data == SYNC) begin
          state_n = CNT2;
          csum_n  = '0;
          ww_n    = '0;
        end
      end
      CNT2, CNT1: begin
        if (accept) begin
          count_n = full_count;
          csum_n  = csum_q ^ s_data;
          state_n = (state == CNT2) ? CNT1 : CNT0;
        end
      end
      CNT0: begin
        if (accept) begin
          count_n = full_count;
          csum_n  = csum_q ^ s_data;
          if (full_count == '0 || full_count > CW'(MAX_WORDS)) begin
            state_n = ERROR;
            err_n   = 1'b1;
            code_n  = 2'b01;
          end else begin
            state_n = DHI;
          end
        end
      end
      DHI: begin
        if (accept) begin
          hi_n    = s_data;
          state_n = DLO;
        end
      end
      DLO: begin
        if (accept) begin
          // hi byte is folded into the checksum here so all of its bits count
          csum_n  = csum_q ^ hi_q ^ s_data;
          we_n    = 1'b1;
          addr_n  = words_written;
          din_n   = DATA_WIDTH'({hi_q, s_data});
          ww_n    = words_written + ADDR_WIDTH'(1);
          state_n = (CW'(words_written) + CW'(1) == count_q) ? CSUM : DHI;
        end
      end
      CSUM: begin
        if (accept) begin
          if (s_data == csum_q) begin
            state_n = DONE;
            done_n  = 1'b1;
            start_n = 1'b1;
          end else begin
            state_n = ERROR;
            err_n   = 1'b1;
            code_n  = 2'b10;
          end
        end
      end
      default: ;
    endcase

    // Inter-byte timeout inside a frame
    if (state == IDLE || state == DONE || state == ERROR || accept) begin
      tcnt_n = '0;
    end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 2)) begin
      tcnt_n  = '0;
      state_n = ERROR;
      err_n   = 1'b1;
      code_n  = 2'b11;
    end else begin
      tcnt_n = tcnt_q + TW'(1);
    end

    if (clear) begin
      state_n = IDLE;
      tcnt_n  = '0;
      we_n    = 1'b0;
      addr_n  = mem_addr;
      din_n   = mem_din;
      ww_n    = words_written;
      done_n  = 1'b0;
      err_n   = 1'b0;
      code_n  = 2'b00;
      start_n = 1'b0;
    end

    ready_n = !(state_n == DONE || state_n == ERROR);
    busy_n  = !(state_n == IDLE || state_n == DONE || state_n == ERROR);
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Randomized bench for instruction_loader against a frame-level reference model.
module tb_instruction_loader;

  localparam int unsigned DW = 11;
  localparam int unsigned AW = 17;
  localparam int unsigned MAXW = 66583;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          reset, clear, s_valid, s_ready;
  logic [7:0]    s_data;
  logic          mem_we, busy, load_done, load_error, start_run;
  logic [AW-1:0] mem_addr, words_written;
  logic [DW-1:0] mem_din;
  logic [1:0]    err_code;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0;
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        exp_done;
  logic [1:0]  exp_code;
  logic [7:0]  frame[$];

  instruction_loader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .busy(busy), .load_done(load_done), .load_error(load_error), .err_code(err_code),
    .words_written(words_written), .start_run(start_run)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      got_addr.push_back(32'(mem_addr));
      got_data.push_back(32'(mem_din));
    end
    if (start_run) start_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Frame-level reference: find sync, read count, collect words, compare checksum
  task automatic model(input logic [7:0] f[$]);
    int idx = 0;
    logic [23:0] cnt;
    logic [7:0]  cs;
    exp_addr.delete();
    exp_data.delete();
    while (idx < f.size() && f[idx] != 8'hA5) idx++;
    idx++;
    cnt = {f[idx], f[idx+1], f[idx+2]};
    cs  = f[idx] ^ f[idx+1] ^ f[idx+2];
    idx += 3;
    if (cnt == 0 || cnt > MAXW) begin
      exp_done = 1'b0;
      exp_code = 2'b01;
      return;
    end
    for (int i = 0; i < int'(cnt); i++) begin
      cs ^= f[idx] ^ f[idx+1];
      exp_addr.push_back(i);
      exp_data.push_back({f[idx], f[idx+1]} & 32'h7FF);
      idx += 2;
    end
    exp_done = (f[idx] == cs);
    exp_code = exp_done ? 2'b00 : 2'b10;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit acc = 0;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        s_valid = 1'b0;
      end
    end
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      s_data  = b;
      s_valid = 1'b1;
      acc = s_ready;
      @(posedge clk);
    end
    if (!acc) check("ready_wait", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] f[$], input bit rnd);
    for (int i = 0; i < f.size(); i++) send_byte(f[i], rnd);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_done", 32'(load_done), 0);
    check("clr_err", 32'(load_error), 0);
    check("clr_code", 32'(err_code), 0);
    check("clr_ready", 32'(s_ready), 1);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] f[$], input bit rnd);
    model(f);
    got_addr.delete();
    got_data.delete();
    start_cnt = 0;
    send_frame(f, rnd);
    repeat (3) @(negedge clk);
    check({tag, "_nwr"}, 32'(got_addr.size()), 32'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check({tag, "_addr"}, got_addr[i], exp_addr[i]);
      check({tag, "_data"}, got_data[i], exp_data[i]);
    end
    check({tag, "_done"}, 32'(load_done), 32'(exp_done));
    check({tag, "_err"}, 32'(load_error), 32'(!exp_done));
    check({tag, "_code"}, 32'(err_code), 32'(exp_code));
    check({tag, "_start"}, start_cnt, exp_done ? 1 : 0);
    check({tag, "_ww"}, 32'(words_written), 32'(exp_addr.size()));
    check({tag, "_ready"}, 32'(s_ready), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    do_clear();
  endtask

  task automatic build_random(output logic [7:0] f[$]);
    int n;
    logic [7:0] cs, b;
    f = {};
    if ($urandom_range(0, 1) == 1) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h5A;
      f.push_back(b);
    end
    n = $urandom_range(1, 6);
    f.push_back(8'hA5);
    f.push_back(8'h00);
    f.push_back(8'h00);
    f.push_back(8'(n));
    cs = 8'(n);
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom_range(0, 255));
      cs ^= b;
      f.push_back(b);
    end
    if ($urandom_range(0, 3) == 0) cs ^= 8'($urandom_range(1, 255));
    f.push_back(cs);
  endtask

  initial begin
    logic [7:0] good[$];
    int n;
    reset = 1'b1;
    clear = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(s_ready), 0);
    check("rst_we", 32'(mem_we), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(load_done), 0);
    check("rst_err", 32'(load_error), 0);
    check("rst_ww", 32'(words_written), 0);
    check("rst_start", 32'(start_run), 0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(s_ready), 1);

    good = {8'hA5, 8'h00, 8'h00, 8'h03, 8'h01, 8'h23, 8'h07, 8'hFF, 8'h04, 8'h00, 8'hDD};
    run_frame("good", good, 0);
    frame = {8'h12, 8'h34, 8'hA5, 8'h00, 8'h00, 8'h01, 8'hF9, 8'hAB, 8'h52};
    run_frame("badcs", frame, 0);
    frame = {8'h12, 8'h34, 8'hA5, 8'h00, 8'h00, 8'h01, 8'hF9, 8'hAB, 8'h53};
    run_frame("junk", frame, 0);
    frame = {8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("cnt0", frame, 0);
    frame = {8'hA5, 8'h01, 8'h04, 8'h18};
    run_frame("cntmax", frame, 0);
    run_frame("goodrnd", good, 1);
    for (int r = 0; r < 12; r++) begin
      build_random(frame);
      run_frame("rand", frame, 1);
    end

    // Timeout: stall after a hi byte
    got_addr.delete();
    frame = {8'hA5, 8'h00, 8'h00, 8'h02, 8'h01};
    for (int i = 0; i < frame.size(); i++) send_byte(frame[i], 0);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      s_valid = 1'b0;
      if (load_error) break;
      @(posedge clk);
      n++;
    end
    check("tmo_cycles", n, 15);
    check("tmo_code", 32'(err_code), 3);
    check("tmo_nwr", 32'(got_addr.size()), 0);
    do_clear();

    // Clear mid-frame after two words
    got_addr.delete();
    frame = {8'hA5, 8'h00, 8'h00, 8'h04, 8'h01, 8'h11, 8'h02, 8'h22};
    send_frame(frame, 0);
    @(negedge clk);
    check("midclr_nwr", 32'(got_addr.size()), 2);
    do_clear();
    check("midclr_busy", 32'(busy), 0);
    check("midclr_ww", 32'(words_written), 2);
    run_frame("after_clr", good, 0);

    // Clear coincident with a DLO accept
    got_addr.delete();
    frame = {8'hA5, 8'h00, 8'h00, 8'h02, 8'h01};
    send_frame(frame, 0);
    @(negedge clk);
    s_data = 8'h23;
    s_valid = 1'b1;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("clr_dlo_nwr", 32'(got_addr.size()), 0);
    check("clr_dlo_busy", 32'(busy), 0);
    check("clr_dlo_ww", 32'(words_written), 0);

    // Reset mid-frame after two words
    frame = {8'hA5, 8'h00, 8'h00, 8'h04, 8'h01, 8'h11, 8'h02, 8'h22};
    send_frame(frame, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ww", 32'(words_written), 0);
    check("midrst_ready", 32'(s_ready), 0);
    check("midrst_we", 32'(mem_we), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_frame("after_rst", good, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
